// File: rtl/stdout_line_drain_pkg.sv
// Shared constants and types for the stdout line drain: FIFO word field
// offsets, the frame header size and the emission state encoding.
package stdout_pkg;
  localparam int CHAR_LSB = 0;
  localparam int CORE_LSB = 8;
  localparam int CL_LSB   = 16;

  localparam logic [7:0] NEWLINE = 8'h0A;

  // cl_idx, core_idx, len precede the body of every frame
  localparam int FRAME_HDR_LEN = 3;

  typedef enum logic [2:0] {
    ACCEPT,
    HDR_CL,
    HDR_CORE,
    HDR_LEN,
    BODY
  } state_e;
endpackage

// File: rtl/stdout_line_drain_if.sv
// FIFO read side plus outgoing byte stream of the line drain.
// master = the drain, slave = the FIFO/host environment.
interface stdout_line_drain_if #(
  parameter int FIFO_DW = 32
);
  logic               fifo_valid_i;
  logic [FIFO_DW-1:0] fifo_data_i;
  logic               fifo_rd_en_o;
  logic               out_valid_o;
  logic [7:0]         out_data_o;
  logic               out_last_o;
  logic               out_ready_i;

  modport master (
    input  fifo_valid_i, fifo_data_i, out_ready_i,
    output fifo_rd_en_o, out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    output fifo_valid_i, fifo_data_i, out_ready_i,
    input  fifo_rd_en_o, out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/stdout_line_mem.sv
// Simple dual-port byte RAM holding every source's partial line.
// One write port, one read port with a registered (1-cycle) read.
module stdout_line_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/stdout_line_drain.sv
// Pops stdout FIFO words, rebuilds one line per (cluster, core) and emits
// each finished line as a framed byte stream: cl, core, len, chars.
module stdout_line_drain
  import stdout_pkg::*;
#(
  parameter int N_CLUSTERS = 4,
  parameter int N_CORES    = 8,
  parameter int MAX_LINE   = 128,
  parameter int FIFO_DW    = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  stdout_line_drain_if.master bus,
  output logic [31:0]         dropped_cnt_o,
  output logic [31:0]         lines_cnt_o
);
  localparam int N_SRC = N_CLUSTERS * N_CORES;
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LEN_W = $clog2(MAX_LINE + 1);
  localparam int DEPTH = N_SRC * MAX_LINE;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e           state;
  logic [LEN_W-1:0] len_q [N_SRC];
  logic [SRC_W-1:0] cur_src;
  logic [7:0]       cur_cl, cur_core;
  logic [LEN_W-1:0] cur_len, idx;
  logic             pend;
  logic             out_valid, out_last;
  logic [7:0]       out_data;

  logic [7:0]       w_ch, w_cl, w_core;
  logic             w_ok, pop, hs, mem_we, mem_re;
  int               src_int;
  logic [SRC_W-1:0] w_src;
  logic [LEN_W-1:0] w_len, w_len_inc, rd_idx;
  logic [AW-1:0]    waddr, raddr;
  logic [7:0]       rdata;
  logic             unused_hi;

  assign unused_hi = ^bus.fifo_data_i[FIFO_DW-1:24];

  always_comb begin
    w_ch      = bus.fifo_data_i[CHAR_LSB +: 8];
    w_core    = bus.fifo_data_i[CORE_LSB +: 8];
    w_cl      = bus.fifo_data_i[CL_LSB +: 8];
    w_ok      = (int'(w_cl) < N_CLUSTERS) && (int'(w_core) < N_CORES);
    src_int   = w_ok ? (int'(w_cl) * N_CORES + int'(w_core)) : 0;
    w_src     = SRC_W'(src_int);
    w_len     = len_q[w_src];
    w_len_inc = w_len + LEN_W'(1);
    waddr     = AW'(src_int * MAX_LINE + int'(w_len));
  end

  assign pop    = (state == ACCEPT) && bus.fifo_valid_i && !rst_i;
  assign hs     = out_valid && bus.out_ready_i;
  assign mem_we = pop && w_ok && (w_ch != NEWLINE);

  // Read of the next body byte is launched on the handshake so it lands
  // in rdata exactly one cycle later, during the bubble in BODY.
  assign mem_re = hs && ((state == HDR_LEN) || ((state == BODY) && !out_last));
  assign rd_idx = (state == HDR_LEN) ? '0 : idx + LEN_W'(1);
  assign raddr  = AW'(int'(cur_src) * MAX_LINE + int'(rd_idx));

  stdout_line_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk_i),
    .we    (mem_we),
    .waddr (waddr),
    .wdata (w_ch),
    .re    (mem_re),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ACCEPT;
      for (int s = 0; s < N_SRC; s++) len_q[s] <= '0;
      cur_src       <= '0;
      cur_cl        <= '0;
      cur_core      <= '0;
      cur_len       <= '0;
      idx           <= '0;
      pend          <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_last      <= 1'b0;
      dropped_cnt_o <= '0;
      lines_cnt_o   <= '0;
    end else begin
      unique case (state)
        ACCEPT: if (pop) begin
          if (!w_ok) begin
            if (dropped_cnt_o != 32'hFFFF_FFFF) dropped_cnt_o <= dropped_cnt_o + 32'd1;
          end else if (w_ch == NEWLINE) begin
            if (w_len != '0) begin
              cur_src   <= w_src;
              cur_cl    <= w_cl;
              cur_core  <= w_core;
              cur_len   <= w_len;
              out_valid <= 1'b1;
              out_data  <= w_cl;
              state     <= HDR_CL;
            end
          end else begin
            len_q[w_src] <= w_len_inc;
            // full buffer flushes without waiting for a newline
            if (w_len_inc == LEN_W'(MAX_LINE)) begin
              cur_src   <= w_src;
              cur_cl    <= w_cl;
              cur_core  <= w_core;
              cur_len   <= w_len_inc;
              out_valid <= 1'b1;
              out_data  <= w_cl;
              state     <= HDR_CL;
            end
          end
        end
        HDR_CL: if (hs) begin
          out_data <= cur_core;
          state    <= HDR_CORE;
        end
        HDR_CORE: if (hs) begin
          out_data <= 8'(cur_len);
          state    <= HDR_LEN;
        end
        HDR_LEN: if (hs) begin
          out_valid <= 1'b0;
          idx       <= '0;
          pend      <= 1'b1;
          state     <= BODY;
        end
        BODY: begin
          if (pend) begin
            out_valid <= 1'b1;
            out_data  <= rdata;
            out_last  <= (idx == cur_len - LEN_W'(1));
            pend      <= 1'b0;
          end else if (hs) begin
            if (out_last) begin
              len_q[cur_src] <= '0;
              lines_cnt_o    <= lines_cnt_o + 32'd1;
              out_valid      <= 1'b0;
              out_last       <= 1'b0;
              out_data       <= '0;
              state          <= ACCEPT;
            end else begin
              out_valid <= 1'b0;
              idx       <= idx + LEN_W'(1);
              pend      <= 1'b1;
            end
          end
        end
        default: state <= ACCEPT;
      endcase
    end
  end

  assign bus.fifo_rd_en_o = pop;
  assign bus.out_valid_o  = out_valid;
  assign bus.out_data_o   = out_data;
  assign bus.out_last_o   = out_last;
endmodule
